// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the single-issue MIPS pipeline. Holds
//            the PC, presents a word address to the asynchronous-read imem,
//            and captures the returned word into the IF/ID pipeline register.
//            Honours redirect (highest priority), stall and flush requests.
// Ports    : clk            - pipeline clock, rising edge
//            rst_n          - asynchronous active-low reset
//            stall          - hold PC and IF/ID
//            flush          - replace IF/ID with a bubble
//            redirect_valid - taken branch/jump from EX
//            redirect_pc    - byte target of the redirect
//            imem_addr      - word address to imem (combinational from PC)
//            imem_rd        - instruction word from imem, same cycle
//            pc             - current fetch PC (byte address)
//            if_id_valid    - IF/ID holds a real instruction
//            if_id_instr    - fetched instruction, 0 (NOP) for a bubble
//            if_id_pc       - byte address of if_id_instr
//            if_id_pc_plus4 - if_id_pc + 4
//            perf_fetch_cnt - (FETCH_PERF_EN) valid IF/ID loads, saturating
//            perf_stall_cnt - (FETCH_PERF_EN) stalled cycles, saturating
// Options  : define FETCH_PERF_EN to add the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    output logic [WIDTH-1:0] pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt,
`endif
    output logic             if_id_valid,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4
);

    localparam logic [WIDTH-1:0] c_ZERO      = '0;
    localparam logic [WIDTH-1:0] c_FOUR      = WIDTH'(4);
    localparam logic [WIDTH-1:0] c_WORD_MASK = ~(WIDTH'(3));

    logic [WIDTH-1:0] r_pc;
    logic             r_if_id_valid;
    logic [WIDTH-1:0] r_if_id_instr;
    logic [WIDTH-1:0] r_if_id_pc;
    logic [WIDTH-1:0] r_if_id_pc_plus4;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_redirect_target;
    logic             w_load_valid;
    logic             w_stall_cycle;

    // Adder wraps naturally modulo 2^WIDTH.
    assign w_pc_plus4        = r_pc + c_FOUR;
    // Redirect targets are forced word-aligned; the low two bits are dropped.
    assign w_redirect_target = redirect_pc & c_WORD_MASK;
    // An IF/ID load with a real instruction happens only on a free-running,
    // unflushed cycle.
    assign w_load_valid      = !redirect_valid && !stall && !flush;
    assign w_stall_cycle     = stall && !redirect_valid;

    assign imem_addr = {2'b00, r_pc[WIDTH-1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_if_id_valid    <= 1'b0;
            r_if_id_instr    <= c_ZERO;
            r_if_id_pc       <= c_ZERO;
            r_if_id_pc_plus4 <= c_ZERO;
        end else if (redirect_valid) begin
            // Redirect overrides stall and flush and always bubbles IF/ID.
            r_pc             <= w_redirect_target;
            r_if_id_valid    <= 1'b0;
            r_if_id_instr    <= c_ZERO;
            r_if_id_pc       <= c_ZERO;
            r_if_id_pc_plus4 <= c_ZERO;
        end else if (stall) begin
            // PC holds so the same instruction is refetched on release.
            if (flush) begin
                r_if_id_valid    <= 1'b0;
                r_if_id_instr    <= c_ZERO;
                r_if_id_pc       <= c_ZERO;
                r_if_id_pc_plus4 <= c_ZERO;
            end
        end else begin
            r_pc <= w_pc_plus4;
            if (flush) begin
                r_if_id_valid    <= 1'b0;
                r_if_id_instr    <= c_ZERO;
                r_if_id_pc       <= c_ZERO;
                r_if_id_pc_plus4 <= c_ZERO;
            end else begin
                r_if_id_valid    <= 1'b1;
                r_if_id_instr    <= imem_rd;
                r_if_id_pc       <= r_pc;
                r_if_id_pc_plus4 <= w_pc_plus4;
            end
        end
    end

    assign pc             = r_pc;
    assign if_id_valid    = r_if_id_valid;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= 32'h0;
            r_perf_stall_cnt <= 32'h0;
        end else begin
            if (w_load_valid && (r_perf_fetch_cnt != c_CNT_MAX)) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'h1;
            end
            if (w_stall_cycle && (r_perf_stall_cnt != c_CNT_MAX)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'h1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`else
    // Counter enables only feed the optional counters; fold them into a
    // sink so the default build carries no dangling logic.
    logic w_perf_unused;
    assign w_perf_unused = w_load_valid ^ w_stall_cycle;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a
//            combinational imem model. Counter checks are compiled in when
//            FETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(
        .RESET_PC (c_RESET_PC),
        .WIDTH    (32)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .pc             (pc),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 16 holds the test-plan instruction; every other word is a
    // recognisable pattern derived from its word address.
    function automatic logic [31:0] imem_word(input logic [31:0] wa);
        if (wa == 32'd16) return 32'h2008_0005;
        return 32'hA500_0000 ^ wa;
    endfunction

    always_comb imem_rd = imem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] rp);
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] ipc, input logic [31:0] pc4, input logic [31:0] npc);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
        chk({tag, ".instr"}, if_id_instr, ins);
        chk({tag, ".ifpc"},  if_id_pc, ipc);
        chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
        chk({tag, ".pc"},    pc, npc);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h40);
        chk("rst.iaddr", imem_addr, 32'h10);

        // First fetch after release
        rst_n = 1'b1;
        step(0, 0, 0, 32'h0);
        chk_ifid("first", 1'b1, 32'h2008_0005, 32'h40, 32'h44, 32'h44);

        // Stall at pc=8 with instruction at 4 held in IF/ID
        step(0, 0, 1, 32'h4);
        chk_ifid("redir4", 1'b0, 32'h0, 32'h0, 32'h0, 32'h4);
        step(0, 0, 0, 32'h0);
        chk_ifid("pre_stall", 1'b1, 32'hA500_0001, 32'h4, 32'h8, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0);
            chk_ifid("stall", 1'b1, 32'hA500_0001, 32'h4, 32'h8, 32'h8);
        end
        step(0, 0, 0, 32'h0);
        chk_ifid("release", 1'b1, 32'hA500_0002, 32'h8, 32'hC, 32'hC);

        // Stall with flush: PC holds, IF/ID bubbles
        step(1, 1, 0, 32'h0);
        chk_ifid("stallflush", 1'b0, 32'h0, 32'h0, 32'h0, 32'hC);

        // Redirect overrides stall; low target bits cleared
        step(1, 0, 1, 32'h0000_0103);
        chk_ifid("redir_stall", 1'b0, 32'h0, 32'h0, 32'h0, 32'h100);
        chk("redir.iaddr", imem_addr, 32'h40);
        step(0, 0, 0, 32'h0);
        chk_ifid("after_redir", 1'b1, 32'hA500_0040, 32'h100, 32'h104, 32'h104);

        // Flush without stall at pc=0x20
        step(0, 0, 1, 32'h20);
        step(0, 1, 0, 32'h0);
        chk_ifid("flush", 1'b0, 32'h0, 32'h0, 32'h0, 32'h24);
        step(0, 0, 0, 32'h0);
        chk_ifid("after_flush", 1'b1, 32'hA500_0009, 32'h24, 32'h28, 32'h28);

        // Wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap.iaddr", imem_addr, 32'h3FFF_FFFF);
        step(0, 0, 0, 32'h0);
        chk_ifid("wrap", 1'b1, 32'hA500_0000 ^ 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0);

        // Redirect to the current PC still bubbles
        step(0, 0, 1, 32'h0);
        chk_ifid("redir_self", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk_ifid("post_self", 1'b1, 32'hA500_0000, 32'h0, 32'h4, 32'h4);

        // Asynchronous reset mid-cycle, with a redirect pending
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #2;
        rst_n = 1'b0;
        #1;
        chk_ifid("arst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h40);
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #1;
        chk("arst.hold", pc, 32'h40);
        rst_n = 1'b1;
        step(0, 0, 0, 32'h0);
        chk_ifid("arst_rel", 1'b1, 32'h2008_0005, 32'h40, 32'h44, 32'h44);

`ifdef FETCH_PERF_EN
        // Counter run from a fresh reset: 5 normal, 2 stall, 1 redirect
        rst_n = 1'b0;
        #2;
        chk("perf.rst_f", perf_fetch_cnt, 32'h0);
        chk("perf.rst_s", perf_stall_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h80);
        chk("perf.fetch", perf_fetch_cnt, 32'd5);
        chk("perf.stall", perf_stall_cnt, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
